jogo_memoria_param: RTL and testbench

//  Parametrised next-generation controller for the sequence-memory game. Plays back the first
//  r+1 sequence items on leds, then checks the player's presses one by one, round by round.

---
 rtl/jogo_memoria_param_pkg.sv | 39 +++
 rtl/jogo_memoria_param_memoria.sv | 28 ++
 rtl/jogo_memoria_param.sv | 186 ++++++++++++++++++
 tb/tb_jogo_memoria_param.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jogo_memoria_param_pkg.sv
// Shared definitions for the sequence-memory game: state codes shown on db_estado,
// counter sizing helpers and the default playback sequence.
package jogo_memoria_param_pkg;

  typedef enum logic [3:0] {
    ST_INICIAL     = 4'd0,
    ST_PREPARA     = 4'd1,
    ST_MOSTRA      = 4'd2,
    ST_ESPERA      = 4'd3,
    ST_REGISTRA    = 4'd4,
    ST_COMPARA     = 4'd5,
    ST_PROX_RODADA = 4'd6,
    ST_FIM_ACERTO  = 4'd7,
    ST_FIM_ERRO    = 4'd8,
    ST_FIM_TIMEOUT = 4'd9
  } estado_t;

  function automatic int maximo3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int largura_contador(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    if (w < 1) w = 1;
    return w;
  endfunction

  // Item k lights button k modulo the button count, one-hot.
  function automatic logic [31:0] seq_padrao(input int k, input int nbotoes);
    return 32'd1 << (k % nbotoes);
  endfunction

endpackage

// File: rtl/jogo_memoria_param_memoria.sv
// Sequence ROM: DEPTH one-hot items of NBOTOES bits, read asynchronously by item index.
// INIT replaces the default rotating pattern when USAR_INIT is set (item 0 in the low bits).
module jogo_memoria_param_memoria
  import jogo_memoria_param_pkg::*;
#(
  parameter int NBOTOES = 4,
  parameter int DEPTH = 16,
  parameter int AW = $clog2(DEPTH),
  parameter bit USAR_INIT = 1'b0,
  parameter logic [DEPTH*NBOTOES-1:0] INIT = '0
) (
  input  logic [AW-1:0]      endereco,
  output logic [NBOTOES-1:0] dado
);

  logic [NBOTOES-1:0] rom [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_rom
    if (USAR_INIT) begin : g_init
      assign rom[i] = INIT[i*NBOTOES +: NBOTOES];
    end else begin : g_padrao
      assign rom[i] = NBOTOES'(seq_padrao(i, NBOTOES));
    end
  end

  assign dado = rom[endereco];

endmodule

// File: rtl/jogo_memoria_param.sv
// Sequence-memory game core: plays back the first r+1 items, then checks the player's
// presses one at a time with a per-press timeout, advancing rounds until win or loss.
//
//  state        | meaning
//  INICIAL      | idle after reset, waiting for jogar
//  PREPARA      | one cycle, clears round/item counters and verdict
//  MOSTRA       | playback of items 0..r, lit window then dark pause each
//  ESPERA       | waiting for a press edge, per-press timer running
//  REGISTRA     | press latched, one cycle
//  COMPARA      | latched press checked against item k
//  PROX_RODADA  | advance round, restart playback
//  FIM_ACERTO   | game won, held until jogar
//  FIM_ERRO     | wrong press, held until jogar
//  FIM_TIMEOUT  | no press in time, held until jogar
module jogo_memoria_param
  import jogo_memoria_param_pkg::*;
#(
  parameter int NBOTOES = 4,
  parameter int DEPTH = 16,
  parameter int RODADAS = 16,
  parameter int TIMEOUT = 3000,
  parameter int T_MOSTRA = 500,
  parameter int T_PAUSA = 250
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       jogar,
  input  logic [NBOTOES-1:0]         botoes,
  output logic [NBOTOES-1:0]         leds,
  output logic                       ganhou,
  output logic                       perdeu,
  output logic                       timeout,
  output logic                       pronto,
  output logic [$clog2(DEPTH)-1:0]   rodada,
  output logic [3:0]                 db_estado
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = largura_contador(maximo3(TIMEOUT, T_MOSTRA, T_PAUSA));

  localparam logic [TW-1:0] CARGA_MOSTRA  = TW'(T_MOSTRA - 1);
  localparam logic [TW-1:0] CARGA_PAUSA   = TW'(T_PAUSA - 1);
  localparam logic [TW-1:0] CARGA_TIMEOUT = TW'(TIMEOUT - 1);
  localparam logic [AW-1:0] ULTIMA_RODADA = AW'(RODADAS - 1);

  estado_t estado, prox_estado;

  logic [AW-1:0]      r, r_prox;
  logic [AW-1:0]      k, k_prox;
  logic [TW-1:0]      timer, timer_prox;
  logic               aceso, aceso_prox;
  logic [NBOTOES-1:0] jogada_reg, jogada_reg_prox;
  logic [NBOTOES-1:0] item;
  logic               prev;
  logic               jogada;

  // prev tracks the button level every cycle, so a press held into ESPERA never
  // produces an edge until it is released and pressed again.
  assign jogada = (|botoes) & ~prev;

  jogo_memoria_param_memoria #(
    .NBOTOES (NBOTOES),
    .DEPTH   (DEPTH),
    .AW      (AW)
  ) u_memoria (
    .endereco (k),
    .dado     (item)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      estado     <= ST_INICIAL;
      r          <= '0;
      k          <= '0;
      timer      <= '0;
      aceso      <= 1'b0;
      jogada_reg <= '0;
      prev       <= 1'b0;
    end else begin
      estado     <= prox_estado;
      r          <= r_prox;
      k          <= k_prox;
      timer      <= timer_prox;
      aceso      <= aceso_prox;
      jogada_reg <= jogada_reg_prox;
      prev       <= |botoes;
    end
  end

  // Timers are down-counters: loaded with length-1, phase ends on the cycle they read zero.
  always_comb begin
    prox_estado     = estado;
    r_prox          = r;
    k_prox          = k;
    timer_prox      = timer;
    aceso_prox      = aceso;
    jogada_reg_prox = jogada_reg;

    case (estado)
      ST_INICIAL: begin
        if (jogar) prox_estado = ST_PREPARA;
      end

      ST_PREPARA: begin
        r_prox          = '0;
        k_prox          = '0;
        timer_prox      = CARGA_MOSTRA;
        aceso_prox      = 1'b1;
        jogada_reg_prox = '0;
        prox_estado     = ST_MOSTRA;
      end

      ST_MOSTRA: begin
        if (timer != '0) begin
          timer_prox = timer - 1'b1;
        end else if (aceso) begin
          aceso_prox = 1'b0;
          timer_prox = CARGA_PAUSA;
        end else if (k == r) begin
          k_prox      = '0;
          timer_prox  = CARGA_TIMEOUT;
          prox_estado = ST_ESPERA;
        end else begin
          k_prox     = k + 1'b1;
          aceso_prox = 1'b1;
          timer_prox = CARGA_MOSTRA;
        end
      end

      ST_ESPERA: begin
        // A press on the terminal cycle is still accepted.
        if (jogada) begin
          jogada_reg_prox = botoes;
          prox_estado     = ST_REGISTRA;
        end else if (timer == '0) begin
          prox_estado = ST_FIM_TIMEOUT;
        end else begin
          timer_prox = timer - 1'b1;
        end
      end

      ST_REGISTRA: begin
        prox_estado = ST_COMPARA;
      end

      ST_COMPARA: begin
        if (jogada_reg != item) begin
          prox_estado = ST_FIM_ERRO;
        end else if (k != r) begin
          k_prox      = k + 1'b1;
          timer_prox  = CARGA_TIMEOUT;
          prox_estado = ST_ESPERA;
        end else if (r == ULTIMA_RODADA) begin
          prox_estado = ST_FIM_ACERTO;
        end else begin
          prox_estado = ST_PROX_RODADA;
        end
      end

      ST_PROX_RODADA: begin
        r_prox      = r + 1'b1;
        k_prox      = '0;
        timer_prox  = CARGA_MOSTRA;
        aceso_prox  = 1'b1;
        prox_estado = ST_MOSTRA;
      end

      ST_FIM_ACERTO, ST_FIM_ERRO, ST_FIM_TIMEOUT: begin
        if (jogar) prox_estado = ST_PREPARA;
      end

      default: begin
        prox_estado = ST_INICIAL;
      end
    endcase
  end

  assign leds      = (estado == ST_MOSTRA && aceso) ? item : '0;
  assign ganhou    = (estado == ST_FIM_ACERTO);
  assign perdeu    = (estado == ST_FIM_ERRO) || (estado == ST_FIM_TIMEOUT);
  assign timeout   = (estado == ST_FIM_TIMEOUT);
  assign pronto    = ganhou | perdeu;
  assign rodada    = r;
  assign db_estado = estado;

endmodule

// File: tb/tb_jogo_memoria_param.sv
// Self-checking bench for jogo_memoria_param with a small configuration; playback and
// press verdicts are predicted by a reference model and checked through scoreboard queues.
module tb_jogo_memoria_param;

  localparam int NB = 4;
  localparam int DP = 4;
  localparam int RD = 4;
  localparam int TO = 20;
  localparam int TM = 3;
  localparam int TP = 2;

  localparam logic [3:0] S_INICIAL  = 4'd0;
  localparam logic [3:0] S_PREPARA  = 4'd1;
  localparam logic [3:0] S_MOSTRA   = 4'd2;
  localparam logic [3:0] S_ESPERA   = 4'd3;
  localparam logic [3:0] S_REGISTRA = 4'd4;
  localparam logic [3:0] S_PROX     = 4'd6;
  localparam logic [3:0] S_ACERTO   = 4'd7;
  localparam logic [3:0] S_ERRO     = 4'd8;
  localparam logic [3:0] S_TIMEOUT  = 4'd9;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          jogar = 1'b0;
  logic [NB-1:0] botoes = '0;
  logic [NB-1:0] leds;
  logic          ganhou, perdeu, timeout, pronto;
  logic [1:0]    rodada;
  logic [3:0]    db_estado;

  int n_checks = 0;
  int n_fail = 0;
  int r_m = 0;
  int k_m = 0;

  logic [NB-1:0] exp_leds_q[$];
  logic [3:0]    exp_estado_q[$];

  jogo_memoria_param #(
    .NBOTOES  (NB),
    .DEPTH    (DP),
    .RODADAS  (RD),
    .TIMEOUT  (TO),
    .T_MOSTRA (TM),
    .T_PAUSA  (TP)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .jogar     (jogar),
    .botoes    (botoes),
    .leds      (leds),
    .ganhou    (ganhou),
    .perdeu    (perdeu),
    .timeout   (timeout),
    .pronto    (pronto),
    .rodada    (rodada),
    .db_estado (db_estado)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [NB-1:0] seq_ref(input int k);
    logic [NB-1:0] um;
    um = 1;
    return um << (k % NB);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic esperar_estado(input logic [3:0] s, input int limite, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limite; i++) begin
      if (db_estado === s) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (db_estado === s) ok = 1'b1;
  endtask

  task automatic aplica_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic inicia_jogo();
    jogar = 1'b1;
    tick();
    jogar = 1'b0;
    r_m = 0;
    k_m = 0;
    n_checks++;
    if (db_estado !== S_PREPARA) begin
      n_fail++;
      $display("FAIL inicia_prepara: db_estado=%0d required=%0d", db_estado, S_PREPARA);
    end
  endtask

  // Pushes the whole expected playback for round rr, then pops one entry per cycle.
  task automatic mostra_rodada(input int rr);
    bit ok;
    logic [NB-1:0] e;
    for (int kk = 0; kk <= rr; kk++) begin
      repeat (TM) exp_leds_q.push_back(seq_ref(kk));
      repeat (TP) exp_leds_q.push_back('0);
    end
    esperar_estado(S_MOSTRA, 10, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL mostra_entrada r=%0d: db_estado=%0d required=%0d", rr, db_estado, S_MOSTRA);
    end
    n_checks++;
    if (rodada !== 2'(rr)) begin
      n_fail++;
      $display("FAIL mostra_rodada: rodada=%0d required=%0d", rodada, rr);
    end
    while (exp_leds_q.size() > 0) begin
      e = exp_leds_q.pop_front();
      n_checks++;
      if (leds !== e) begin
        n_fail++;
        $display("FAIL leds r=%0d: leds=%b required=%b", rr, leds, e);
      end
      tick();
    end
    n_checks++;
    if (db_estado !== S_ESPERA) begin
      n_fail++;
      $display("FAIL espera_apos_mostra r=%0d: db_estado=%0d required=%0d", rr, db_estado, S_ESPERA);
    end
  endtask

  // Model predicts the verdict when the press is driven; compared three edges later.
  task automatic pressiona(input logic [NB-1:0] v);
    logic [3:0] e;
    if (v !== seq_ref(k_m)) begin
      e = S_ERRO;
    end else if (k_m < r_m) begin
      e = S_ESPERA;
      k_m++;
    end else if (r_m == RD - 1) begin
      e = S_ACERTO;
    end else begin
      e = S_PROX;
      r_m++;
      k_m = 0;
    end
    exp_estado_q.push_back(e);
    botoes = v;
    tick();
    n_checks++;
    if (db_estado !== S_REGISTRA) begin
      n_fail++;
      $display("FAIL registra botoes=%b: db_estado=%0d required=%0d", v, db_estado, S_REGISTRA);
    end
    botoes = '0;
    tick();
    tick();
    e = exp_estado_q.pop_front();
    n_checks++;
    if (db_estado !== e) begin
      n_fail++;
      $display("FAIL veredito botoes=%b: db_estado=%0d required=%0d", v, db_estado, e);
    end
  endtask

  task automatic test_reset();
    aplica_reset();
    repeat (10) tick();
    n_checks++;
    if (db_estado !== S_INICIAL) begin n_fail++; $display("FAIL reset_estado: db_estado=%0d required=%0d", db_estado, S_INICIAL); end
    n_checks++;
    if (leds !== '0) begin n_fail++; $display("FAIL reset_leds: leds=%b required=0000", leds); end
    n_checks++;
    if ({ganhou, perdeu, timeout, pronto} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: ganhou/perdeu/timeout/pronto=%b required=0000", {ganhou, perdeu, timeout, pronto});
    end
    n_checks++;
    if (rodada !== 2'd0) begin n_fail++; $display("FAIL reset_rodada: rodada=%0d required=0", rodada); end
    jogar = 1'b1;
    repeat (5) tick();
    jogar = 1'b0;
    n_checks++;
    if (db_estado !== S_MOSTRA) begin n_fail++; $display("FAIL jogar_mantido_estado: db_estado=%0d required=%0d", db_estado, S_MOSTRA); end
    n_checks++;
    if (leds !== '0) begin n_fail++; $display("FAIL jogar_mantido_pausa: leds=%b required=0000", leds); end
    aplica_reset();
    n_checks++;
    if (db_estado !== S_INICIAL) begin n_fail++; $display("FAIL reset_em_mostra: db_estado=%0d required=%0d", db_estado, S_INICIAL); end
  endtask

  task automatic test_primeira_rodada();
    inicia_jogo();
    mostra_rodada(0);
    pressiona(seq_ref(0));
    mostra_rodada(1);
    aplica_reset();
  endtask

  task automatic test_jogo_completo();
    inicia_jogo();
    for (int rr = 0; rr < RD; rr++) begin
      mostra_rodada(rr);
      for (int kk = 0; kk <= rr; kk++) pressiona(seq_ref(kk));
    end
    repeat (3) tick();
    n_checks++;
    if ({ganhou, pronto, perdeu, timeout} !== 4'b1100) begin
      n_fail++;
      $display("FAIL vitoria_flags: ganhou/pronto/perdeu/timeout=%b required=1100", {ganhou, pronto, perdeu, timeout});
    end
    n_checks++;
    if (rodada !== 2'd3) begin n_fail++; $display("FAIL vitoria_rodada: rodada=%0d required=3", rodada); end
    n_checks++;
    if (db_estado !== S_ACERTO) begin n_fail++; $display("FAIL vitoria_mantida: db_estado=%0d required=%0d", db_estado, S_ACERTO); end
  endtask

  task automatic test_erro();
    inicia_jogo();
    mostra_rodada(0);
    pressiona(4'b0001);
    mostra_rodada(1);
    pressiona(4'b0001);
    pressiona(4'b0100);
    n_checks++;
    if ({perdeu, timeout, pronto, ganhou} !== 4'b1010) begin
      n_fail++;
      $display("FAIL erro_flags: perdeu/timeout/pronto/ganhou=%b required=1010", {perdeu, timeout, pronto, ganhou});
    end
    inicia_jogo();
    mostra_rodada(0);
    pressiona(4'b0011);
    n_checks++;
    if (perdeu !== 1'b1) begin n_fail++; $display("FAIL multi_press_perdeu: perdeu=%b required=1", perdeu); end
  endtask

  task automatic test_timeout();
    inicia_jogo();
    mostra_rodada(0);
    repeat (TO - 1) tick();
    n_checks++;
    if (db_estado !== S_ESPERA) begin n_fail++; $display("FAIL timeout_antes: db_estado=%0d required=%0d", db_estado, S_ESPERA); end
    tick();
    n_checks++;
    if (db_estado !== S_TIMEOUT) begin n_fail++; $display("FAIL timeout_estado: db_estado=%0d required=%0d", db_estado, S_TIMEOUT); end
    n_checks++;
    if ({perdeu, timeout, pronto} !== 3'b111) begin
      n_fail++;
      $display("FAIL timeout_flags: perdeu/timeout/pronto=%b required=111", {perdeu, timeout, pronto});
    end
    inicia_jogo();
    mostra_rodada(0);
    repeat (TO - 1) tick();
    pressiona(seq_ref(0));
    aplica_reset();
  endtask

  task automatic test_botao_segurado();
    inicia_jogo();
    botoes = 4'b0001;
    mostra_rodada(0);
    jogar = 1'b1;
    repeat (5) tick();
    jogar = 1'b0;
    n_checks++;
    if (db_estado !== S_ESPERA) begin n_fail++; $display("FAIL botao_segurado: db_estado=%0d required=%0d", db_estado, S_ESPERA); end
    botoes = '0;
    tick();
    pressiona(seq_ref(0));
    tick();
    tick();
    n_checks++;
    if (leds !== 4'b0001) begin n_fail++; $display("FAIL pre_reset_leds: leds=%b required=0001", leds); end
    aplica_reset();
    n_checks++;
    if (db_estado !== S_INICIAL || leds !== '0 || rodada !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_meio_jogo: db_estado=%0d leds=%b rodada=%0d required %0d 0000 0", db_estado, leds, rodada, S_INICIAL);
    end
    inicia_jogo();
    mostra_rodada(0);
    pressiona(4'b0010);
    inicia_jogo();
    n_checks++;
    if ({perdeu, pronto, timeout, ganhou} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reinicio_flags: perdeu/pronto/timeout/ganhou=%b required=0000", {perdeu, pronto, timeout, ganhou});
    end
    mostra_rodada(0);
  endtask

  initial begin
    test_reset();
    test_primeira_rodada();
    test_jogo_completo();
    test_erro();
    test_timeout();
    test_botao_segurado();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
